// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the 32-bit RISC-V datapath.
// It decodes the latched instruction, sequences FETCH/DECODE/execute
// and handles the data-memory ready handshake with a bounded wait.
//
// Parameter:
//   WAIT_MAX    - cycles to wait for mem_ready before completing anyway
// Macro:
//   ILLEGAL_TRAP_EN - adds the sticky 'illegal' output; illegal opcodes
//                     jump the PC to 0 instead of acting as a NOP
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   instr       - instruction register contents (loaded when ir_en=1)
//   zero        - ALU result is zero
//   mem_ready   - data memory finished the current access
//   MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc, ResultSrc, PCSrc
//               - datapath controls
//   pc_en, ir_en - PC / instruction register load enables
//   mem_timeout - sticky: a memory wait reached WAIT_MAX
//   illegal     - sticky illegal-instruction flag (ILLEGAL_TRAP_EN only)
//   state_dbg   - current state encoding
module multicycle_control_fsm #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        MemWrite,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic [1:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  PCSrc,
   output logic        pc_en,
   output logic        ir_en,
   output logic        mem_timeout,
`ifdef ILLEGAL_TRAP_EN
   output logic        illegal,
`endif
   output logic [3:0]  state_dbg
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic [3:0] {
      S_BOOT    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_ALU_WB  = 4'd3,
      S_MEM_RD  = 4'd4,
      S_MEM_WB  = 4'd5,
      S_MEM_WR  = 4'd6,
      S_BRANCH  = 4'd7,
      S_JUMP    = 4'd8,
      S_ILLEGAL = 4'd9
   } state_t;

   state_t          state;
   state_t          next;
   state_t          d_next;
   logic [CW-1:0]   cnt;
   logic            to_set;
   logic            d_alusrc;
   logic [1:0]      d_alu;
   logic [1:0]      d_imm;
   logic [1:0]      d_res;
   logic            d_jalr;
   logic            wait_end;
   logic            unused_bits;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;

   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   assign state_dbg = state;

   // Instruction decode; the controls it produces stay valid for the
   // whole instruction because instr only changes during FETCH.
   always_comb begin
      d_next   = S_ILLEGAL;
      d_alusrc = 1'b0;
      d_alu    = 2'b00;
      d_imm    = 2'b00;
      d_res    = 2'b00;
      d_jalr   = 1'b0;
      unique case (1'b1)
         op == OP_R: begin
            if (f7 == 7'b0000000 && f3 == 3'b000) begin
               d_next = S_ALU_WB;
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               d_next = S_ALU_WB;
               d_alu  = 2'b01;
            end else if (f7 == 7'b0000000 && f3 == 3'b111) begin
               d_next = S_ALU_WB;
               d_alu  = 2'b10;
            end else if (f7 == 7'b0000000 && f3 == 3'b110) begin
               d_next = S_ALU_WB;
               d_alu  = 2'b11;
            end
         end
         op == OP_I: begin
            d_alusrc = 1'b1;
            if (f3 == 3'b000) begin
               d_next = S_ALU_WB;
            end else if (f3 == 3'b111) begin
               d_next = S_ALU_WB;
               d_alu  = 2'b10;
            end else if (f3 == 3'b110) begin
               d_next = S_ALU_WB;
               d_alu  = 2'b11;
            end
         end
         op == OP_LW: begin
            d_next   = S_MEM_RD;
            d_alusrc = 1'b1;
            d_res    = 2'b01;
         end
         op == OP_SW: begin
            d_next   = S_MEM_WR;
            d_alusrc = 1'b1;
            d_imm    = 2'b01;
         end
         op == OP_BR: begin
            d_alu = 2'b01;
            d_imm = 2'b10;
            if (f3 == 3'b000) d_next = S_BRANCH;
         end
         op == OP_JAL: begin
            d_next = S_JUMP;
            d_imm  = 2'b11;
            d_res  = 2'b11;
         end
         op == OP_JALR: begin
            d_next   = S_JUMP;
            d_alusrc = 1'b1;
            d_res    = 2'b11;
            d_jalr   = 1'b1;
         end
         default: ;
      endcase
   end

   // Memory wait ends on ready, or when the counter is saturated;
   // a ready in the saturating cycle is a normal completion.
   assign wait_end = mem_ready || (cnt == WMAX);

   always_comb begin
      next       = state;
      to_set     = 1'b0;
      MemWrite   = 1'b0;
      ALUSrc     = 1'b0;
      RegWrite   = 1'b0;
      ALUControl = 2'b00;
      ImmSrc     = 2'b00;
      ResultSrc  = 2'b00;
      PCSrc      = 2'b00;
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      if (state != S_BOOT && state != S_FETCH &&
          state != S_ILLEGAL) begin
         ALUSrc     = d_alusrc;
         ALUControl = d_alu;
         ImmSrc     = d_imm;
         ResultSrc  = d_res;
      end
      case (state)
         S_BOOT: begin
            pc_en = 1'b1;
            PCSrc = 2'b11;
            next  = S_FETCH;
         end
         S_FETCH: begin
            ir_en = 1'b1;
            next  = S_DECODE;
         end
         S_DECODE: begin
            next = d_next;
         end
         S_ALU_WB: begin
            RegWrite  = 1'b1;
            ResultSrc = 2'b00;
            pc_en     = 1'b1;
            next      = S_FETCH;
         end
         S_MEM_RD: begin
            if (wait_end) begin
               next   = S_MEM_WB;
               to_set = !mem_ready;
            end
         end
         S_MEM_WB: begin
            RegWrite  = 1'b1;
            ResultSrc = 2'b01;
            pc_en     = 1'b1;
            next      = S_FETCH;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            if (wait_end) begin
               pc_en  = 1'b1;
               next   = S_FETCH;
               to_set = !mem_ready;
            end
         end
         S_BRANCH: begin
            pc_en = 1'b1;
            PCSrc = zero ? 2'b01 : 2'b00;
            next  = S_FETCH;
         end
         S_JUMP: begin
            RegWrite = 1'b1;
            pc_en    = 1'b1;
            PCSrc    = d_jalr ? 2'b10 : 2'b01;
            next     = S_FETCH;
         end
         S_ILLEGAL: begin
            pc_en = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            PCSrc = 2'b11;
`endif
            next  = S_FETCH;
         end
         default: next = S_FETCH;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   assign illegal = illegal_q || (state == S_ILLEGAL);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_BOOT;
         cnt         <= '0;
         mem_timeout <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q   <= 1'b0;
`endif
      end else begin
         state <= next;
         if (state == S_DECODE) begin
            cnt <= '0;
         end else if ((state == S_MEM_RD || state == S_MEM_WR) &&
                      cnt != WMAX) begin
            cnt <= cnt + CW'(1);
         end
         if (to_set) mem_timeout <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
         if (state == S_ILLEGAL) illegal_q <= 1'b1;
`endif
      end
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control FSM that sequences the 32-bit RISC-V datapath (register file, 4-op ALU, data memory, extend unit, PC register) over several cycles per instruction.
- Decodes the latched instruction and drives MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc, ResultSrc and PCSrc.
- Gates PC and instruction-register updates through enables, and waits on a data-memory ready handshake.
- Replaces the external control currently supplied by the test bench.

Parameters:
- WAIT_MAX, 15, maximum cycles spent waiting for mem_ready before forcing completion; counter width is $clog2(WAIT_MAX+1).

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction from instruction memory, latched externally when ir_en=1
- zero  in  1  ALU result == 0
- mem_ready  in  1  data memory completed the current access
- MemWrite  out  1  data memory write strobe
- ALUSrc  out  1  0=register operand B, 1=ImmExt
- RegWrite  out  1  register file write
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 or
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ResultSrc  out  2  00 ALU, 01 memory, 10 ImmExt, 11 PC+4
- PCSrc  out  2  00 PC+4, 01 PC+imm, 10 {ALU[31:1],0}, 11 zero vector
- pc_en  out  1  PC register load enable
- ir_en  out  1  instruction register load enable
- mem_timeout  out  1  sticky: a memory wait hit WAIT_MAX
- state_dbg  out  4  current state encoding

Behaviour:
- Reset
  - rst=1 on an edge sets state BOOT, clears the wait counter and mem_timeout.
  - All outputs are 0 while in BOOT, except pc_en=1 and PCSrc=11, so the PC loads 0 on the first edge after rst falls.
  - rst asserted mid-instruction aborts it; no RegWrite or MemWrite pulse follows.
- States and encodings
  - BOOT=0, FETCH=1, DECODE=2, ALU_WB=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, BRANCH=7, JUMP=8, ILLEGAL=9.
  - Unused encodings go to FETCH.
- BOOT -> FETCH.
- FETCH
  - ir_en=1; all write strobes 0.
  - -> DECODE.
- DECODE
  - Decode opcode instr[6:0].
  - Control outputs (ALUSrc, ALUControl, ImmSrc, ResultSrc) become valid here and hold stable until the instruction's final state completes.
  - No strobes asserted.
  - Transitions by opcode:
    - 0110011 (R) and 0010011 (I-ALU) -> ALU_WB
    - 0000011 (lw) -> MEM_RD
    - 0100011 (sw) -> MEM_WR
    - 1100011 (beq, funct3=000) -> BRANCH
    - 1101111 (jal) and 1100111 (jalr) -> JUMP
    - anything else -> ILLEGAL
- ALU decode
  - R-type:
    - funct3=000, funct7[5]=0 -> 00
    - funct3=000, funct7[5]=1 -> 01
    - funct3=111 -> 10
    - funct3=110 -> 11
  - I-ALU: funct3 000 -> 00, 111 -> 10, 110 -> 11.
  - lw, sw, jalr use 00; beq uses 01.
  - Any other funct3/funct7 combination for R or I-ALU -> ILLEGAL.
- ALU_WB
  - RegWrite=1, ResultSrc=00, pc_en=1, PCSrc=00.
  - -> FETCH.
- MEM_RD
  - ALUSrc=1, ImmSrc=00; wait for mem_ready.
  - -> MEM_WB when mem_ready=1 or the wait count reaches WAIT_MAX. On timeout, set mem_timeout.
- MEM_WB
  - RegWrite=1, ResultSrc=01, pc_en=1, PCSrc=00.
  - -> FETCH.
- MEM_WR
  - MemWrite=1, ImmSrc=01, ALUSrc=1, held every cycle until mem_ready or timeout.
  - On the completing cycle: pc_en=1, PCSrc=00, then -> FETCH.
  - A mem_ready already high on the first MEM_WR cycle completes in one cycle.
- BRANCH
  - ALUSrc=0, ImmSrc=10, ALUControl=01.
  - pc_en=1, PCSrc = zero ? 01 : 00.
  - -> FETCH.
- JUMP
  - RegWrite=1, ResultSrc=11, pc_en=1.
  - jal: ImmSrc=11, PCSrc=01.
  - jalr: ImmSrc=00, ALUSrc=1, PCSrc=10.
  - -> FETCH.
- Wait counter
  - Cleared on entry to MEM_RD/MEM_WR; increments each waiting cycle; saturates.
  - mem_ready arriving in the same cycle the counter reaches WAIT_MAX counts as normal completion; mem_timeout is not set.
- Latency with mem_ready held high
  - 3 cycles: R/I, sw, beq, jal, jalr.
  - 4 cycles: lw.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal (1 bit, sticky until rst).
  - ILLEGAL asserts illegal=1, pc_en=1, PCSrc=11 (PC<=0), then -> FETCH.
- Not defined:
  - No illegal port.
  - ILLEGAL acts as a NOP: pc_en=1, PCSrc=00, no strobes, then -> FETCH.

Test Plan:
- rst high 2 cycles, then released -> BOOT cycle shows pc_en=1, PCSrc=11; next state_dbg=1 with ir_en=1; all strobes 0 throughout.
- instr=0x002081B3 (add x3,x1,x2), mem_ready=1 -> exactly 3 cycles FETCH/DECODE/ALU_WB; ALUControl=00, ALUSrc=0; RegWrite=1 and pc_en=1 only in cycle 3.
- instr=0x00802283 (lw x5,8(x0)), mem_ready low 3 cycles then high -> MEM_RD held 4 cycles, then MEM_WB with RegWrite=1, ResultSrc=01; total 7 cycles; mem_timeout=0.
- instr=0x00502623 (sw), mem_ready stuck low -> MemWrite=1 for WAIT_MAX+1 cycles; mem_timeout=1 and stays 1; FSM returns to FETCH.
- instr=0x00000463 (beq x0,x0,8): zero=1 -> PCSrc=01, pc_en=1; zero=0 -> PCSrc=00. instr=0x010000EF (jal x1,16) -> RegWrite=1, ResultSrc=11, ImmSrc=11, PCSrc=01.
- instr=0xFFFFFFFF -> with ILLEGAL_TRAP_EN: illegal=1, PCSrc=11; without: PCSrc=00, no strobes. rst asserted in MEM_WR -> MemWrite=0 on the next cycle, state BOOT.
